// File: rtl/bist_misr_compactor_if.sv
// Handshake and data bundle between the BIST controller and the MISR.
// master drives start/abort/num_words/golden/din; slave reports status.
interface bist_misr_compactor_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  start;
    logic                  abort;
    logic [CNT_WIDTH-1:0]  num_words;
    logic [DATA_WIDTH-1:0] golden;
    logic                  din_valid;
    logic [DATA_WIDTH-1:0] din;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [DATA_WIDTH-1:0] signature;
    logic [CNT_WIDTH-1:0]  word_count;

    modport master (
        output start, abort, num_words, golden,
        output din_valid, din,
        input  busy, done, pass, signature, word_count
    );

    modport slave (
        input  start, abort, num_words, golden,
        input  din_valid, din,
        output busy, done, pass, signature, word_count
    );
endinterface

// File: rtl/bist_misr_compactor.sv
// MISR response compactor: folds din into a signature, checks golden.
// Ports: clk, rst (async high), bus (slave: control in, status out).
module bist_misr_compactor #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] POLY       = 32'h04C11DB7,
    parameter logic [DATA_WIDTH-1:0] SEED       = 32'h00000000,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    bist_misr_compactor_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sig_q, sig_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  nw_q, nw_d;
    logic [DATA_WIDTH-1:0] gold_q, gold_d;
    logic                  pass_q, pass_d;

    logic [DATA_WIDTH-1:0] sig_mix;
    logic [CNT_WIDTH-1:0]  cnt_inc;

    assign sig_mix = {sig_q[DATA_WIDTH-2:0], 1'b0}
                   ^ (sig_q[DATA_WIDTH-1] ? POLY : '0)
                   ^ bus.din;
    assign cnt_inc = cnt_q + CNT_WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            nw_q    <= '0;
            gold_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            nw_q    <= nw_d;
            gold_q  <= gold_d;
            pass_q  <= pass_d;
        end
    end

    // abort outranks start, and start outranks a word in the same cycle;
    // the pass flag is resolved on the edge that enters DONE.
    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        nw_d    = nw_q;
        gold_d  = gold_q;
        pass_d  = pass_q;
        priority case (1'b1)
            bus.abort: begin
                state_d = IDLE;
                pass_d  = 1'b0;
            end
            bus.start: begin
                nw_d   = bus.num_words;
                gold_d = bus.golden;
                sig_d  = SEED;
                cnt_d  = '0;
                if (bus.num_words == '0) begin
                    state_d = DONE;
                    pass_d  = (SEED == bus.golden);
                end else begin
                    state_d = RUN;
                    pass_d  = 1'b0;
                end
            end
            (state_q == RUN) && bus.din_valid: begin
                sig_d = sig_mix;
                cnt_d = cnt_inc;
                if (cnt_inc == nw_q) begin
                    state_d = DONE;
                    pass_d  = (sig_mix == gold_q);
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.busy       = (state_q == RUN);
    assign bus.done       = (state_q == DONE);
    assign bus.pass       = pass_q;
    assign bus.signature  = sig_q;
    assign bus.word_count = cnt_q;
endmodule

// File: tb/tb_bist_misr_compactor.sv
// Randomized self-checking bench for bist_misr_compactor.
// Compares DUT status each cycle against a word-stream reference model.
module tb_bist_misr_compactor;
    localparam int          W    = 32;
    localparam int          C    = 16;
    localparam logic [31:0] POLY = 32'h04C11DB7;
    localparam logic [31:0] SEED = 32'h00000000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bist_misr_compactor_if #(.DATA_WIDTH(W), .CNT_WIDTH(C)) bus();

    bist_misr_compactor #(
        .DATA_WIDTH(W), .POLY(POLY), .SEED(SEED), .CNT_WIDTH(C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: 0 idle, 1 running, 2 finished.
    int          m_st;
    logic [31:0] m_sig, m_gold;
    logic [15:0] m_cnt, m_n;
    logic        m_pass;
    logic        m_absorbed;
    logic [31:0] pend[$];

    // One MISR step as polynomial arithmetic: multiply by x, reduce
    // modulo x^32 + POLY, add the new word.
    function automatic logic [31:0] fold(input logic [31:0] s,
                                         input logic [31:0] d);
        logic [32:0] v;
        v = {1'b0, s} << 1;
        if (v[32]) v = v ^ {1'b1, POLY};
        return v[31:0] ^ d;
    endfunction

    function automatic logic [31:0] sig_of(input logic [31:0] ws[$]);
        logic [31:0] s = SEED;
        foreach (ws[i]) s = fold(s, ws[i]);
        return s;
    endfunction

    task automatic model_reset();
        m_st = 0; m_sig = SEED; m_cnt = '0; m_n = '0;
        m_gold = '0; m_pass = 1'b0;
    endtask

    task automatic model_step();
        m_absorbed = 1'b0;
        if (bus.abort) begin
            m_st = 0;
            m_pass = 1'b0;
        end else if (bus.start) begin
            m_n = bus.num_words;
            m_gold = bus.golden;
            m_sig = SEED;
            m_cnt = '0;
            m_st = (bus.num_words == 0) ? 2 : 1;
            m_pass = (bus.num_words == 0) && (bus.golden == SEED);
        end else if (m_st == 1 && bus.din_valid) begin
            m_sig = fold(m_sig, bus.din);
            m_cnt = m_cnt + 16'd1;
            m_absorbed = 1'b1;
            if (m_cnt == m_n) begin
                m_st = 2;
                m_pass = (m_sig == m_gold);
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".busy"}, 64'(bus.busy), 64'(m_st == 1));
        chk({tag, ".done"}, 64'(bus.done), 64'(m_st == 2));
        if (m_st == 2) chk({tag, ".pass"}, 64'(bus.pass), 64'(m_pass));
        chk({tag, ".sig"}, 64'(bus.signature), 64'(m_sig));
        chk({tag, ".cnt"}, 64'(bus.word_count), 64'(m_cnt));
    endtask

    task automatic drive(input logic st, input logic ab,
                         input logic [15:0] nw, input logic [31:0] g,
                         input logic dv, input logic [31:0] d,
                         input string tag);
        bus.start = st; bus.abort = ab; bus.num_words = nw;
        bus.golden = g; bus.din_valid = dv; bus.din = d;
        @(posedge clk);
        model_step();
        #1;
        bus.start = 1'b0; bus.abort = 1'b0; bus.din_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
        chk({tag, ".done"}, 64'(bus.done), 64'd0);
        chk({tag, ".pass"}, 64'(bus.pass), 64'd0);
        chk({tag, ".sig"}, 64'(bus.signature), 64'(SEED));
        chk({tag, ".cnt"}, 64'(bus.word_count), 64'd0);
        model_reset();
        pend.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        bus.start = 0; bus.abort = 0; bus.num_words = 0;
        bus.golden = 0; bus.din_valid = 0; bus.din = 0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        idle("post_reset");

        drive(1, 0, 16'd1, 32'hDEADBEEF, 0, '0, "w1_start");
        drive(0, 0, '0, '0, 1, 32'hDEADBEEF, "w1_word");
        chk("w1.done", 64'(bus.done), 64'd1);
        chk("w1.pass", 64'(bus.pass), 64'd1);
        chk("w1.sig", 64'(bus.signature), 64'hDEADBEEF);
        chk("w1.cnt", 64'(bus.word_count), 64'd1);

        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? 32'h7364AA97 : 32'h7364AA96;
            drive(1, 0, 16'd2, w, 0, '0, "w2_start");
            drive(0, 0, '0, '0, 1, 32'hDEADBEEF, "w2_a");
            chk("w2.sig1", 64'(bus.signature), 64'hDEADBEEF);
            idle("w2_gap");
            chk("w2.gap", 64'(bus.signature), 64'hDEADBEEF);
            drive(0, 0, '0, '0, 1, 32'hCAFECAFE, "w2_b");
            chk("w2.sig", 64'(bus.signature), 64'h7364AA97);
            chk("w2.done", 64'(bus.done), 64'd1);
            chk("w2.pass", 64'(bus.pass), (k == 0) ? 64'd1 : 64'd0);
            idle("w2_hold");
        end

        drive(1, 0, 16'd0, SEED, 0, '0, "zero_ok");
        chk("zero.pass1", 64'(bus.pass), 64'd1);
        drive(1, 0, 16'd0, 32'h5, 0, '0, "zero_bad");
        chk("zero.pass0", 64'(bus.pass), 64'd0);
        chk("zero.done", 64'(bus.done), 64'd1);

        drive(1, 0, 16'd3, '0, 0, '0, "ab_start");
        drive(0, 0, '0, '0, 1, 32'h12345678, "ab_w");
        drive(0, 1, '0, '0, 0, '0, "ab_abort");
        chk("ab.busy", 64'(bus.busy), 64'd0);
        chk("ab.cnt", 64'(bus.word_count), 64'd1);
        drive(0, 0, '0, '0, 1, 32'hFFFF0000, "ab_ignored");
        chk("ab.hold", 64'(bus.signature), 64'h12345678);

        drive(1, 0, 16'd4, '0, 0, '0, "sim_start");
        drive(0, 0, '0, '0, 1, 32'h0BADF00D, "sim_w");
        drive(1, 1, 16'd2, '0, 1, 32'h11111111, "sim_all");
        chk("sim.idle", 64'({bus.busy, bus.done}), 64'd0);
        drive(1, 0, 16'd0, '0, 0, '0, "sim_done");
        drive(1, 0, 16'd2, '0, 1, 32'h22222222, "rearm");
        chk("rearm.busy", 64'(bus.busy), 64'd1);
        chk("rearm.sig", 64'(bus.signature), 64'(SEED));
        chk("rearm.cnt", 64'(bus.word_count), 64'd0);
        drive(1, 0, 16'd3, '0, 1, 32'h33333333, "restart");
        chk("restart.cnt", 64'(bus.word_count), 64'd0);

        drive(0, 0, '0, '0, 1, 32'hA5A5A5A5, "rst_w");
        async_reset("rst_mid");
        idle("rst_after");

        for (int i = 0; i < 3000; i++) begin
            int r;
            logic st, ab, dv;
            logic [15:0] nw;
            logic [31:0] g, d;
            r  = $urandom_range(0, 999);
            ab = (r >= 975);
            st = (r < 30) || (m_st != 1 && r < 150);
            dv = ($urandom_range(0, 3) != 0);
            nw = 16'($urandom_range(0, 6));
            g  = $urandom;
            if (st && !ab) begin
                pend.delete();
                for (int j = 0; j < int'(nw); j++) pend.push_back($urandom);
                if ($urandom_range(0, 1) == 1) g = sig_of(pend);
            end
            d = (pend.size() != 0) ? pend[0] : $urandom;
            if (r == 500) begin
                async_reset("rnd_rst");
            end else begin
                drive(st, ab, nw, g, dv, d, "rnd");
                if (m_absorbed && pend.size() != 0) void'(pend.pop_front());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
